painterengine_gpu_dma_reader_arbiter: RTL and testbench
=======================================================

Name: painterengine_gpu_dma_reader_arbiter

Overview:
- Shares one painterengine_gpu_dma_reader instance between 4 requesters (texture, framebuffer and similar fetch units) using round-robin arbitration.
- Per job it latches the winner's address and length, drives the reader's one-hot router, and restarts the reader through its active-low reset.
- It then waits for reader done or error and reports a per-requester completion or error pulse.
- The reader's data lanes stay routed by the router, so the granted requester receives data directly from the reader.

Parameters:
C_RESET_HOLD, 2, cycles o_wire_reader_resetn is held low before each job (min 1)
C_WATCHDOG_WIDTH, 20, width of backstop job watchdog; fires when MSB sets (2^19 cycles in RUN)

Ports:
i_wire_clock  in  1  clock
i_wire_reset  in  1  synchronous active-high reset
i_wire_req  in  4  level request per requester
i_wire_address  in  128  per-requester 32-bit word-aligned byte address, slot n = [n*32+:32]
i_wire_length  in  128  per-requester length in 32-bit words, slot n = [n*32+:32]
o_wire_grant  out  4  one-hot current owner, 0 when idle
o_wire_done  out  4  1-cycle pulse, job of requester n completed
o_wire_error  out  4  1-cycle pulse, job of requester n failed
o_wire_error_type  out  3  error code of most recent failed job (sticky)
o_wire_busy  out  1  high in every state except IDLE
o_wire_reader_resetn  out  1  active-low reset to reader
o_wire_reader_router  out  4  one-hot router to reader
o_wire_reader_address  out  128  latched address placed in granted slot, other slots 0
o_wire_reader_length  out  128  latched length placed in granted slot, other slots 0
i_wire_reader_done  in  1  reader done level
i_wire_reader_error  in  1  reader error level
i_wire_reader_error_type  in  3  reader error code

Behaviour:
- Reset values (next edge with i_wire_reset=1):
  - state IDLE; grant/done/error/router/address/length/busy = 0; error_type = 0; reader_resetn = 0.
  - RR pointer = 3, so requester 0 has top priority first.
  - Reset mid-job aborts it with no done/error pulse; the reader is reset on the same edge.
- States IDLE -> GRANT -> RUN -> REPORT -> IDLE.
- IDLE:
  - reader_resetn = 0, router = 0.
  - If any req bit is set, select the first set bit searching pointer+1, pointer+2, ... mod 4.
  - Next edge: latch that slot's address/length, set grant/router to its one-hot, set pointer to the winner, load hold counter with C_RESET_HOLD, go to GRANT.
- GRANT:
  - reader_resetn = 0; router, address and length are already stable.
  - Decrement the counter; at 1, the next edge sets reader_resetn = 1, clears the watchdog and enters RUN.
  - Router is stable at least C_RESET_HOLD cycles before reset release, so the reader samples a valid route.
- RUN:
  - reader_resetn = 1, watchdog increments each cycle.
  - reader_error=1: record error_type = i_wire_reader_error_type, go to REPORT as error. Error wins over simultaneous done.
  - Else reader_done=1: go to REPORT as done.
  - Else watchdog MSB set: error_type = 3'b110 (arbiter watchdog), go to REPORT as error. Done or error seen in the same cycle wins over watchdog.
- REPORT (exactly 1 cycle):
  - done or error bit of the granted slot = 1; reader_resetn = 0.
  - Next edge: grant = 0, router = 0, address/length = 0, go to IDLE.
- Request handling:
  - Req is sampled only in IDLE.
  - Req deasserting during a job does not abort it; the pulse is still issued.
  - A requester must not change its address/length slot while granted (values are already latched; later changes are ignored).
- Minimum job overhead: 1 (IDLE) + C_RESET_HOLD + 1 (REPORT) cycles besides reader time. Back-to-back grants are separated by at least one IDLE cycle.
- Fairness: with all 4 req held high, grants go 0,1,2,3,0,...; no requester waits more than 3 jobs.
- Counters: hold counter is 8 bits; watchdog is C_WATCHDOG_WIDTH bits and does not wrap (the MSB trip ends RUN).

Test Plan:
1. Single job: req=4'b0001, address[31:0]=0x1000_0000, length[31:0]=40 → after 1 cycle grant=0001, router=0001; resetn low 2 cycles then high; the AXI model delivers 40 words (bursts 32+8); one cycle after reader done, o_wire_done=0001 for 1 cycle; busy drops the next cycle.
2. Round robin: req=4'b1111 held, each job length 4 → grant order 0001,0010,0100,1000,0001; each done pulse matches the preceding grant.
3. Reader error: slot 1 address=0x1000_0002 (misaligned) → reader error type 3'b010; o_wire_error=0010 pulse, o_wire_error_type=3'b010; next req=0001 with a good address completes with done=0001 and error_type still 3'b010.
4. Watchdog: AXI model never asserts ARREADY, C_WATCHDOG_WIDTH=8 → o_wire_error pulse after 128 RUN cycles, error_type=3'b110, reader_resetn=0 in REPORT.
5. Simultaneous done and error in the same cycle (forced reader stub) → error pulse only, error_type taken from the reader.
6. Reset mid-job: assert i_wire_reset during RUN of slot 2 → next edge grant=0, reader_resetn=0, no pulses; after release with req=4'b0101, slot 0 is granted first (pointer restored to 3).

Source files
------------

// File: rtl/painterengine_gpu_dma_reader_arbiter_if.sv
// Bus bundle between the requesters, the reader arbiter and the shared DMA reader.
// The slave modport is the arbiter's view; master is the requester/reader side.
interface painterengine_gpu_dma_reader_arbiter_if;
    logic [3:0]   i_wire_req;
    logic [127:0] i_wire_address;
    logic [127:0] i_wire_length;
    logic [3:0]   o_wire_grant;
    logic [3:0]   o_wire_done;
    logic [3:0]   o_wire_error;
    logic [2:0]   o_wire_error_type;
    logic         o_wire_busy;
    logic         o_wire_reader_resetn;
    logic [3:0]   o_wire_reader_router;
    logic [127:0] o_wire_reader_address;
    logic [127:0] o_wire_reader_length;
    logic         i_wire_reader_done;
    logic         i_wire_reader_error;
    logic [2:0]   i_wire_reader_error_type;

    modport slave (
        input  i_wire_req, i_wire_address, i_wire_length,
        input  i_wire_reader_done, i_wire_reader_error, i_wire_reader_error_type,
        output o_wire_grant, o_wire_done, o_wire_error, o_wire_error_type, o_wire_busy,
        output o_wire_reader_resetn, o_wire_reader_router, o_wire_reader_address, o_wire_reader_length
    );

    modport master (
        output i_wire_req, i_wire_address, i_wire_length,
        output i_wire_reader_done, i_wire_reader_error, i_wire_reader_error_type,
        input  o_wire_grant, o_wire_done, o_wire_error, o_wire_error_type, o_wire_busy,
        input  o_wire_reader_resetn, o_wire_reader_router, o_wire_reader_address, o_wire_reader_length
    );
endinterface

// File: rtl/painterengine_gpu_dma_reader_arbiter.sv
// Round-robin arbiter sharing one DMA reader between 4 requesters; each job
// restarts the reader through its active-low reset and reports a per-slot pulse.
module painterengine_gpu_dma_reader_arbiter #(
    parameter int C_RESET_HOLD     = 2,
    parameter int C_WATCHDOG_WIDTH = 20
) (
    input logic                                  i_wire_clock,
    input logic                                  i_wire_reset,
    painterengine_gpu_dma_reader_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RUN, ST_REPORT} state_t;

    state_t                      state, state_nxt;
    logic [1:0]                  ptr, ptr_nxt;
    logic [1:0]                  win;
    logic                        found;
    logic [3:0]                  grant, grant_nxt;
    logic [127:0]                addr_q, addr_nxt;
    logic [127:0]                len_q, len_nxt;
    logic [7:0]                  hold, hold_nxt;
    logic [C_WATCHDOG_WIDTH-1:0] wd, wd_nxt;
    logic                        is_err, is_err_nxt;
    logic [2:0]                  etype, etype_nxt;

    // First set request searching ptr+1, ptr+2, ... so the last winner goes last.
    always_comb begin
        logic [1:0] idx;
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + i[1:0];
            if (!found && bus.i_wire_req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        grant_nxt  = grant;
        addr_nxt   = addr_q;
        len_nxt    = len_q;
        hold_nxt   = hold;
        wd_nxt     = wd;
        is_err_nxt = is_err;
        etype_nxt  = etype;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_nxt = ST_GRANT;
                    grant_nxt = 4'b0001 << win;
                    ptr_nxt   = win;
                    hold_nxt  = C_RESET_HOLD[7:0];
                    addr_nxt  = '0;
                    len_nxt   = '0;
                    addr_nxt[win*32 +: 32] = bus.i_wire_address[win*32 +: 32];
                    len_nxt[win*32 +: 32]  = bus.i_wire_length[win*32 +: 32];
                end
            end
            ST_GRANT: begin
                if (hold == 8'd1) begin
                    state_nxt = ST_RUN;
                    wd_nxt    = '0;
                end else begin
                    hold_nxt = hold - 8'd1;
                end
            end
            ST_RUN: begin
                wd_nxt = wd + 1'b1;
                // Error beats done, and either beats the watchdog trip.
                if (bus.i_wire_reader_error) begin
                    state_nxt  = ST_REPORT;
                    is_err_nxt = 1'b1;
                    etype_nxt  = bus.i_wire_reader_error_type;
                end else if (bus.i_wire_reader_done) begin
                    state_nxt  = ST_REPORT;
                    is_err_nxt = 1'b0;
                end else if (wd[C_WATCHDOG_WIDTH-1]) begin
                    state_nxt  = ST_REPORT;
                    is_err_nxt = 1'b1;
                    etype_nxt  = 3'b110;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
                addr_nxt  = '0;
                len_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            state  <= ST_IDLE;
            ptr    <= 2'd3;
            grant  <= '0;
            addr_q <= '0;
            len_q  <= '0;
            hold   <= '0;
            wd     <= '0;
            is_err <= 1'b0;
            etype  <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            grant  <= grant_nxt;
            addr_q <= addr_nxt;
            len_q  <= len_nxt;
            hold   <= hold_nxt;
            wd     <= wd_nxt;
            is_err <= is_err_nxt;
            etype  <= etype_nxt;
        end
    end

    assign bus.o_wire_grant          = grant;
    assign bus.o_wire_reader_router  = grant;
    assign bus.o_wire_reader_address = addr_q;
    assign bus.o_wire_reader_length  = len_q;
    assign bus.o_wire_error_type     = etype;
    assign bus.o_wire_busy           = (state != ST_IDLE);
    assign bus.o_wire_reader_resetn  = (state == ST_RUN);
    assign bus.o_wire_done           = (state == ST_REPORT && !is_err) ? grant : 4'b0000;
    assign bus.o_wire_error          = (state == ST_REPORT &&  is_err) ? grant : 4'b0000;
endmodule

// File: tb/tb_painterengine_gpu_dma_reader_arbiter.sv
// Directed plus randomized bench for the DMA reader arbiter with a behavioural
// reader stub driven from the stimulus sequence.
module tb_painterengine_gpu_dma_reader_arbiter;
    localparam int HOLD = 2;
    localparam int WDW  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    painterengine_gpu_dma_reader_arbiter_if bus ();

    painterengine_gpu_dma_reader_arbiter #(
        .C_RESET_HOLD     (HOLD),
        .C_WATCHDOG_WIDTH (WDW)
    ) dut (
        .i_wire_clock (clk),
        .i_wire_reset (rst),
        .bus          (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         ptr_m;
    logic [2:0] etype_m;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester after the previous winner, wrapping mod 4.
    function automatic int pick(input logic [3:0] req);
        for (int off = 1; off <= 4; off++) begin
            if (req[(ptr_m + off) % 4]) return (ptr_m + off) % 4;
        end
        return -1;
    endfunction

    task automatic randomize_slots();
        for (int n = 0; n < 4; n++) begin
            bus.i_wire_address[n*32 +: 32] = $urandom & 32'hFFFF_FFFC;
            bus.i_wire_length[n*32 +: 32]  = $urandom_range(1, 64);
        end
    endtask

    // mode: 0 done, 1 error, 2 done+error together, 3 reader silent (watchdog)
    task automatic run_job(input logic [3:0] req, input int mode, input logic [2:0] et, input int lat);
        int           w;
        int           run_cycles;
        logic [127:0] exp_a;
        logic [127:0] exp_l;
        logic [3:0]   oh;
        bus.i_wire_req = req;
        w = pick(req);
        oh = 4'b0001 << w;
        exp_a = '0;
        exp_l = '0;
        exp_a[w*32 +: 32] = bus.i_wire_address[w*32 +: 32];
        exp_l[w*32 +: 32] = bus.i_wire_length[w*32 +: 32];
        @(negedge clk);
        check("grant", bus.o_wire_grant, oh);
        check("router", bus.o_wire_reader_router, oh);
        check("address", bus.o_wire_reader_address, exp_a);
        check("length", bus.o_wire_reader_length, exp_l);
        check("busy_grant", bus.o_wire_busy, 1'b1);
        check("resetn_hold0", bus.o_wire_reader_resetn, 1'b0);
        ptr_m = w;
        // Slot contents change while granted; the latched copy must not follow.
        randomize_slots();
        bus.i_wire_req = $urandom_range(0, 15);
        for (int i = 0; i < HOLD - 1; i++) begin
            @(negedge clk);
            check("resetn_hold", bus.o_wire_reader_resetn, 1'b0);
        end
        @(negedge clk);
        check("resetn_release", bus.o_wire_reader_resetn, 1'b1);
        check("address_latched", bus.o_wire_reader_address, exp_a);
        check("length_latched", bus.o_wire_reader_length, exp_l);
        if (mode < 3) begin
            repeat (lat) @(negedge clk);
            bus.i_wire_reader_done       = (mode != 1);
            bus.i_wire_reader_error      = (mode != 0);
            bus.i_wire_reader_error_type = (mode == 0) ? 3'($urandom) : et;
            @(negedge clk);
            if (mode != 0) etype_m = et;
        end else begin
            // 2^(WDW-1) increments to set the MSB, plus the cycle that sees it.
            run_cycles = 0;
            while (bus.o_wire_reader_resetn === 1'b1 && run_cycles < 400) begin
                run_cycles++;
                @(negedge clk);
            end
            check("watchdog_run_cycles", run_cycles, (1 << (WDW - 1)) + 1);
            etype_m = 3'b110;
        end
        check("done_pulse", bus.o_wire_done, (mode == 0) ? oh : 4'b0000);
        check("error_pulse", bus.o_wire_error, (mode != 0) ? oh : 4'b0000);
        check("error_type", bus.o_wire_error_type, etype_m);
        check("resetn_report", bus.o_wire_reader_resetn, 1'b0);
        check("busy_report", bus.o_wire_busy, 1'b1);
        bus.i_wire_reader_done  = 1'b0;
        bus.i_wire_reader_error = 1'b0;
        bus.i_wire_req          = 4'b0000;
        @(negedge clk);
        check("done_cleared", bus.o_wire_done, 4'b0000);
        check("error_cleared", bus.o_wire_error, 4'b0000);
        check("grant_idle", bus.o_wire_grant, 4'b0000);
        check("address_idle", bus.o_wire_reader_address, 128'd0);
        check("busy_idle", bus.o_wire_busy, 1'b0);
        check("error_type_sticky", bus.o_wire_error_type, etype_m);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_wire_req = '0;
        bus.i_wire_address = '0;
        bus.i_wire_length = '0;
        bus.i_wire_reader_done = 1'b0;
        bus.i_wire_reader_error = 1'b0;
        bus.i_wire_reader_error_type = '0;
        ptr_m = 3;
        etype_m = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_grant", bus.o_wire_grant, 4'b0000);
        check("rst_busy", bus.o_wire_busy, 1'b0);
        check("rst_resetn", bus.o_wire_reader_resetn, 1'b0);
        check("rst_error_type", bus.o_wire_error_type, 3'b000);
        check("rst_address", bus.o_wire_reader_address, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single job on slot 0
        randomize_slots();
        bus.i_wire_address[31:0] = 32'h1000_0000;
        bus.i_wire_length[31:0]  = 32'd40;
        run_job(4'b0001, 0, 3'b000, 5);

        // All requesters held: strict rotation
        for (int j = 0; j < 5; j++) begin
            randomize_slots();
            run_job(4'b1111, 0, 3'b000, 1);
        end

        // Reader error on slot 1, then a clean job keeps the sticky code
        randomize_slots();
        bus.i_wire_address[63:32] = 32'h1000_0002;
        run_job(4'b0010, 1, 3'b010, 2);
        randomize_slots();
        run_job(4'b0001, 0, 3'b000, 3);

        // Watchdog with a silent reader
        randomize_slots();
        run_job(4'b0100, 3, 3'b000, 0);

        // Done and error on the same cycle
        randomize_slots();
        run_job(4'b1000, 2, 3'b101, 0);

        // Randomized traffic
        for (int j = 0; j < 30; j++) begin
            randomize_slots();
            run_job(4'($urandom_range(1, 15)), $urandom_range(0, 2), 3'($urandom_range(0, 5)), $urandom_range(0, 6));
        end

        // Reset during RUN of slot 2
        randomize_slots();
        bus.i_wire_req = 4'b0100;
        @(negedge clk);
        check("mid_grant", bus.o_wire_grant, 4'b0100);
        repeat (HOLD) @(negedge clk);
        check("mid_run", bus.o_wire_reader_resetn, 1'b1);
        bus.i_wire_req = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_grant", bus.o_wire_grant, 4'b0000);
        check("mid_rst_resetn", bus.o_wire_reader_resetn, 1'b0);
        check("mid_rst_done", bus.o_wire_done, 4'b0000);
        check("mid_rst_error", bus.o_wire_error, 4'b0000);
        check("mid_rst_busy", bus.o_wire_busy, 1'b0);
        rst = 1'b0;
        ptr_m = 3;
        etype_m = 3'b000;
        @(negedge clk);
        randomize_slots();
        run_job(4'b0101, 0, 3'b000, 2);
        randomize_slots();
        run_job(4'b0101, 0, 3'b000, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
